mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Parametrised N-host arbiter connecting Ibex-style instruction and data request ports to one single-port RAM (`ram_1p`, 1-cycle read latency). Replaces the hard-wired two-port instruction-priority mux in the bench with round-robin arbitration. Adds same-cycle grant, per-host response routing, and an address-window check that returns bus errors. Sits between `ibex_core` (plus any bench DMA/monitor hosts) and the memory model.

## Interface
- `NumHosts`, 2: number of requesting hosts, 1..8.
- `MemStart`, 32'h0000_0000: base address of the RAM window; must be aligned to `MemSize`.
- `MemSize`, 65536: window size in bytes; power of two, at most 2^31.
- `clk_i` in 1: clock. One clock domain only.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `host_req_i` in NumHosts: per-host request.
- `host_we_i` in NumHosts: per-host write enable.
- `host_be_i` in NumHosts x 4: byte enables.
- `host_addr_i` in NumHosts x 32: byte address.
- `host_wdata_i` in NumHosts x 32: write data.
- `host_gnt_o` out NumHosts: grant, one-hot or zero.
- `host_rvalid_o` out NumHosts: response valid, one-hot or zero.
- `host_rdata_o` out NumHosts x 32: read data; all hosts see the same bus value.
- `host_err_o` out NumHosts: error, valid with `host_rvalid_o`.
- `mem_req_o` out 1: RAM request.
- `mem_we_o` out 1: RAM write enable.
- `mem_be_o` out 4: RAM byte enables.
- `mem_addr_o` out 32: RAM address.
- `mem_wdata_o` out 32: RAM write data.
- `mem_rvalid_i` in 1: RAM response, asserted 1 cycle after `mem_req_o`.
- `mem_rdata_i` in 32: RAM read data.

## Operation
- Index width: `IdxW = max(1, $clog2(NumHosts))`.
- **Arbitration, combinational.** Among the hosts asserting `host_req_i`, the winner is the first one found scanning upward from `last_q+1` modulo `NumHosts`.
- The winner gets `host_gnt_o` in the same cycle. All other hosts get 0.
- **In-window request** (`(addr & ~(MemSize-1)) == MemStart`):
  - `mem_req_o` = 1.
  - `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wdata_o` are driven from the winner.
  - `mem_addr_o` passes through unmodified.
- **Out-of-window request:**
  - The request is still granted.
  - `mem_req_o` stays 0.
  - An error response is scheduled instead.
- **When no request is granted:** the `mem_*` outputs are 0.
- **Response tracking registers:**
  - `rsp_valid_q` is set when any grant occurs.
  - `rsp_idx_q` holds the winner index.
  - `rsp_err_q` holds the out-of-window flag.
- **Response in the following cycle:**
  - `host_rvalid_o[rsp_idx_q] = rsp_valid_q & (rsp_err_q | mem_rvalid_i)`.
  - `host_err_o[rsp_idx_q] = rsp_valid_q & rsp_err_q`.
  - `host_rdata_o = rsp_err_q ? 0 : mem_rdata_i`.
  - Writes also receive `rvalid`.
- **Pointer update:** `last_q` is updated to the winner index on every grant. It holds when there is no grant.
- **Pipelining:** back-to-back grants are allowed every cycle with no bubble.
- **Single host:** with `NumHosts == 1`, `last_q` is a constant and host 0 always wins.
- **Checks, simulation only:**
  - `mem_rvalid_i` without a pending in-window request.
  - `host_gnt_o` not one-hot0.
  - Both assertions are gated by `rst_ni`.

## Timing
- **Reset values (`rst_ni` low):**
  - `last_q = NumHosts-1`, so host 0 wins first after reset.
  - `rsp_valid_q = 0`, `rsp_idx_q = 0`, `rsp_err_q = 0`.
- **Outputs forced during reset:** `host_gnt_o`, `mem_req_o`, `host_rvalid_o` and `host_err_o` are forced to 0 combinationally while `rst_ni` is low.
- **Reset mid-operation:** an outstanding response is discarded. Its `rvalid` is never delivered.
- **Latency:** `req` to `gnt` is 0 cycles. `gnt` to `rvalid` is exactly 1 cycle, for both RAM and error responses.
- **Handshake:**
  - A host holds `req` and its attributes stable until `gnt`.
  - Attributes are sampled only in the grant cycle.
  - A host may drop `req` after `gnt` or keep it asserted for the next transaction.
- **Simultaneous events:** a grant to host B and the response to host A occur in the same cycle without conflict.
- **Fairness bound:** a continuously requesting host is granted within `NumHosts` cycles.

## Configuration
- **Macro:** `MEM_RR_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority; the lowest index wins. `last_q` is not implemented. This reproduces the legacy instruction-over-data ordering with instr on host 0.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Reset release:** hosts 0 and 1 both request addr 0x80 right after reset release -> cycle 0: `gnt=2'b01`. Next cycle: `gnt=2'b10`, and host 0 receives `rvalid` with RAM data at 0x80.
- **Continuous contention:** hosts 0 and 1 request continuously for 6 cycles -> grants alternate 01, 10, 01, 10, 01, 10. `rvalid` follows each grant by exactly 1 cycle to the matching host.
- **Write then read-back:**
  - Host 1 writes 0xDEADBEEF with `be=4'b0011` to 0x100 over existing value 0x11223344.
  - Host 1 then reads 0x100 -> `rdata=0x1122BEEF`, `err=0`.
- **Out-of-window access:** host 0 reads 0x0001_0000 (window `MemSize` 64 KiB) -> `gnt` same cycle, `mem_req_o=0`; next cycle `rvalid=1`, `err=1`, `rdata=0`.
- **Reset mid-operation:** `rst_ni` asserted the cycle after a grant -> no `rvalid` is ever delivered. After release the first grant goes to host 0.
- **`MEM_RR_ARB_FIXED_PRIO_EN` defined:** hosts 0 and 1 request continuously for 4 cycles -> `gnt=2'b01` every cycle, and host 1 is never granted.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: N-host arbiter in front of a single-port RAM with 1-cycle read latency.
// Grants the winner in the request cycle and routes the RAM or error response
// back to it one cycle later. Requests outside the RAM window are granted but
// never reach the RAM, and they return a bus error instead.
// Optional build macro: MEM_RR_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) in place of round-robin.
module mem_rr_arbiter #(
    parameter int unsigned NumHosts = 2,
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter logic [31:0] MemSize  = 32'd65536
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumHosts-1:0]      host_req_i,
    input  logic [NumHosts-1:0]      host_we_i,
    input  logic [NumHosts-1:0][3:0] host_be_i,
    input  logic [NumHosts-1:0][31:0] host_addr_i,
    input  logic [NumHosts-1:0][31:0] host_wdata_i,
    output logic [NumHosts-1:0]      host_gnt_o,
    output logic [NumHosts-1:0]      host_rvalid_o,
    output logic [NumHosts-1:0][31:0] host_rdata_o,
    output logic [NumHosts-1:0]      host_err_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i
);

    localparam int unsigned IdxW    = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam logic [31:0] WinMask = ~(MemSize - 32'd1);

    logic                w_any_req;
    logic [IdxW-1:0]     w_win;
    logic [NumHosts-1:0] w_sel;
    logic [NumHosts-1:0] w_gnt;
    logic                w_gnt_any;
    logic                w_we;
    logic [3:0]          w_be;
    logic [31:0]         w_addr;
    logic [31:0]         w_wdata;
    logic                w_in_win;

    logic                r_rsp_valid;
    logic [IdxW-1:0]     r_rsp_idx;
    logic                r_rsp_err;

    assign w_any_req = |host_req_i;

`ifdef MEM_RR_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning down means the last hit is the lowest requester
    always_comb begin
        w_win = '0;
        for (int j = int'(NumHosts) - 1; j >= 0; j--) begin
            if (host_req_i[j]) w_win = IdxW'(j);
        end
    end
`else
    logic [IdxW-1:0] r_last;

    // Round-robin: lowest requester above r_last, else wrap to the lowest requester
    always_comb begin
        w_win = '0;
        for (int j = int'(NumHosts) - 1; j >= 0; j--) begin
            if (host_req_i[j]) w_win = IdxW'(j);
        end
        for (int j = int'(NumHosts) - 1; j >= 0; j--) begin
            if (host_req_i[j] && (j > int'(r_last))) w_win = IdxW'(j);
        end
    end

    // Last-winner pointer; reset to the top index so host 0 wins first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= IdxW'(NumHosts - 1);
        end else if (w_gnt_any) begin
            r_last <= w_win;
        end
    end
`endif

    // One-hot winner select and attribute mux; grants are suppressed during reset
    always_comb begin
        w_sel   = '0;
        w_gnt   = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int j = 0; j < int'(NumHosts); j++) begin
            w_sel[j] = w_any_req && (int'(w_win) == j);
            w_gnt[j] = rst_ni && w_sel[j];
            w_we     = w_we    | (w_sel[j] & host_we_i[j]);
            w_be     = w_be    | ({4{w_sel[j]}} & host_be_i[j]);
            w_addr   = w_addr  | ({32{w_sel[j]}} & host_addr_i[j]);
            w_wdata  = w_wdata | ({32{w_sel[j]}} & host_wdata_i[j]);
        end
    end

    assign w_gnt_any  = |w_gnt;
    assign w_in_win   = ((w_addr & WinMask) == MemStart);
    assign host_gnt_o = w_gnt;

    // RAM port: driven only for a granted in-window request, otherwise all zero
    always_comb begin
        mem_req_o   = w_gnt_any && w_in_win;
        mem_we_o    = mem_req_o & w_we;
        mem_be_o    = {4{mem_req_o}} & w_be;
        mem_addr_o  = {32{mem_req_o}} & w_addr;
        mem_wdata_o = {32{mem_req_o}} & w_wdata;
    end

    // Response tracking: who was granted last cycle and whether it was an error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_rsp_idx <= w_win;
                r_rsp_err <= !w_in_win;
            end
        end
    end

    // Response routing to the tracked host; read data is broadcast
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int j = 0; j < int'(NumHosts); j++) begin
            host_rvalid_o[j] = rst_ni && r_rsp_valid && (int'(r_rsp_idx) == j)
                               && (r_rsp_err || mem_rvalid_i);
            host_err_o[j]    = rst_ni && r_rsp_valid && (int'(r_rsp_idx) == j)
                               && r_rsp_err;
            host_rdata_o[j]  = r_rsp_err ? 32'h0 : mem_rdata_i;
        end
    end

    // RAM must only answer an outstanding in-window request
    a_rvalid_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (r_rsp_valid && !r_rsp_err));

    // At most one grant per cycle
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(host_gnt_o));

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter (2 hosts) with a 1-cycle-latency RAM model.
module tb_mem_rr_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;
    logic             mem_req;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_rr_arbiter #(
        .NumHosts(2),
        .MemStart(32'h0000_0000),
        .MemSize (32'd65536)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_req_i   (req),
        .host_we_i    (we),
        .host_be_i    (be),
        .host_addr_i  (addr),
        .host_wdata_i (wdata),
        .host_gnt_o   (gnt),
        .host_rvalid_o(rvalid),
        .host_rdata_o (rdata),
        .host_err_o   (err),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word k holds A500_0000 | (4k), except 0x100 holds 1122_3344
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'h0;
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | (32'(i) << 2);
            ram[64] <= 32'h1122_3344;
        end else begin
            mem_rvalid <= mem_req;
            if (mem_req) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) ram[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end else begin
                    mem_rdata <= ram[mem_addr[11:2]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                         input logic w1, input logic [3:0] b1, input logic [31:0] d1);
        req      = r;
        we       = {w1, 1'b0};
        be       = {b1, 4'hF};
        addr     = {a1, a0};
        wdata    = {d1, 32'h0};
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        we1;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic [1:0]  gnt;
        logic        mreq;
        logic [31:0] maddr;
        logic        mwe;
        logic [1:0]  rvalid;
        logic [1:0]  err;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t vec [13];

    task automatic run_table();
        vec[0]  = '{2'b11, 1'b0, 4'hF, 32'h80,    32'h80,  32'h0,         2'b01, 1'b1, 32'h80,  1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vec[1]  = '{2'b11, 1'b0, 4'hF, 32'h80,    32'h80,  32'h0,         2'b10, 1'b1, 32'h80,  1'b0, 2'b01, 2'b00, 1'b1, 32'hA500_0080};
        vec[2]  = '{2'b11, 1'b0, 4'hF, 32'h84,    32'h88,  32'h0,         2'b01, 1'b1, 32'h84,  1'b0, 2'b10, 2'b00, 1'b1, 32'hA500_0080};
        vec[3]  = '{2'b11, 1'b0, 4'hF, 32'h84,    32'h88,  32'h0,         2'b10, 1'b1, 32'h88,  1'b0, 2'b01, 2'b00, 1'b1, 32'hA500_0084};
        vec[4]  = '{2'b11, 1'b0, 4'hF, 32'h84,    32'h88,  32'h0,         2'b01, 1'b1, 32'h84,  1'b0, 2'b10, 2'b00, 1'b1, 32'hA500_0088};
        vec[5]  = '{2'b11, 1'b0, 4'hF, 32'h84,    32'h88,  32'h0,         2'b10, 1'b1, 32'h88,  1'b0, 2'b01, 2'b00, 1'b1, 32'hA500_0084};
        vec[6]  = '{2'b10, 1'b1, 4'h3, 32'h84,    32'h100, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h100, 1'b1, 2'b10, 2'b00, 1'b1, 32'hA500_0088};
        vec[7]  = '{2'b10, 1'b0, 4'hF, 32'h84,    32'h100, 32'h0,         2'b10, 1'b1, 32'h100, 1'b0, 2'b10, 2'b00, 1'b0, 32'h0};
        vec[8]  = '{2'b01, 1'b0, 4'hF, 32'h1_0000, 32'h100, 32'h0,        2'b01, 1'b0, 32'h0,   1'b0, 2'b10, 2'b00, 1'b1, 32'h1122_BEEF};
        vec[9]  = '{2'b00, 1'b0, 4'hF, 32'h0,     32'h0,   32'h0,         2'b00, 1'b0, 32'h0,   1'b0, 2'b01, 2'b01, 1'b1, 32'h0};
        vec[10] = '{2'b00, 1'b0, 4'hF, 32'h0,     32'h0,   32'h0,         2'b00, 1'b0, 32'h0,   1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vec[11] = '{2'b11, 1'b0, 4'hF, 32'h80,    32'h80,  32'h0,         2'b10, 1'b1, 32'h80,  1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        vec[12] = '{2'b00, 1'b0, 4'hF, 32'h0,     32'h0,   32'h0,         2'b00, 1'b0, 32'h0,   1'b0, 2'b10, 2'b00, 1'b1, 32'hA500_0080};

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].req, vec[i].a0, vec[i].a1, vec[i].we1, vec[i].be1, vec[i].wd1);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i),    32'(gnt),     32'(vec[i].gnt));
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vec[i].mreq));
            chk($sformatf("v%0d rvalid", i), 32'(rvalid),  32'(vec[i].rvalid));
            chk($sformatf("v%0d err", i),    32'(err),     32'(vec[i].err));
            if (vec[i].mreq || vec[i].gnt == 2'b00) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr,     vec[i].maddr);
                chk($sformatf("v%0d mem_we", i),   32'(mem_we),  32'(vec[i].mwe));
            end
            if (vec[i].chk_rd) begin
                chk($sformatf("v%0d rdata0", i), rdata[0], vec[i].rdata);
                chk($sformatf("v%0d rdata1", i), rdata[1], vec[i].rdata);
            end
            next_cycle();
        end
    endtask

    // Reset asserted the cycle after a grant: response dropped, host 0 wins first after release
    task automatic run_reset_mid();
        drive(2'b01, 32'h80, 32'h0, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("mid gnt before reset", 32'(gnt), 32'h1);
        next_cycle();
        rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("mid rvalid in reset c%0d", c), 32'(rvalid), 32'h0);
            next_cycle();
        end
        rst_n = 1'b1;
        drive(2'b11, 32'h80, 32'h84, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("post reset gnt", 32'(gnt), 32'h1);
        chk("post reset rvalid", 32'(rvalid), 32'h0);
        next_cycle();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("post reset rsp rvalid", 32'(rvalid), 32'h1);
        chk("post reset rsp rdata", rdata[0], 32'hA500_0080);
        next_cycle();
    endtask

    // Fixed priority build: host 0 always wins under contention
    task automatic run_fixed();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h80, 32'h84, 1'b0, 4'hF, 32'h0);
            @(negedge clk);
            chk($sformatf("fixed gnt c%0d", c), 32'(gnt), 32'h1);
            chk($sformatf("fixed rvalid c%0d", c), 32'(rvalid), (c == 0) ? 32'h0 : 32'h1);
            next_cycle();
        end
        drive(2'b00, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("fixed last rvalid", 32'(rvalid), 32'h1);
        chk("fixed last rdata", rdata[0], 32'hA500_0080);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        // Requests during reset must not be granted
        drive(2'b11, 32'h80, 32'h80, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        next_cycle();
        rst_n = 1'b1;
`ifdef MEM_RR_ARB_FIXED_PRIO_EN
        run_fixed();
`else
        run_table();
        run_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
